string_tx: RTL
==============

# string_tx

Parametrised null-terminated string transmitter: on a start pulse it walks a synchronous byte memory from a selectable base address and serialises each byte as an 8N1/8N2 UART frame until a terminator byte or a length limit is reached. It replaces the separate string FSM and fixed-rate UART transmitter pair with one single-clock block. The block uses an internal baud divider instead of a dedicated UART clock. It sits between the message memory and the serial pin in the top level.

## Interface
- BAUD_DIV, 208: clock cycles per UART bit (24 MHz / 115200); legal range ≥ 2.
- ADDR_W, 8: memory address width.
- STOP_BITS, 1: stop bits per frame; only 1 and 2 are legal.
- TERM, 8'h00: terminator byte; it is never transmitted.
- MAX_LEN, 2**ADDR_W: maximum bytes sent per message.
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request to send a message; honoured only in IDLE.
- base_i  in  ADDR_W  first address of the message; sampled with an accepted start_i.
- abort_i  in  1  stop after the current frame.
- addr_o  out  ADDR_W  memory read address (registered).
- data_i  in  8  memory read data, valid one clock after addr_o changes.
- tx_o  out  1  serial line, idle high.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the message ends.
- aborted_o  out  1  with done_o: message ended by abort_i; held until next start.
- count_o  out  ADDR_W+1  bytes fully transmitted in the current/last message.

## Operation
- Reset values: addr_o=0, tx_o=1, busy_o=0, done_o=0, aborted_o=0, count_o=0, state IDLE. Reset mid-frame drives tx_o high at the next edge with no completion of the frame. rst_i wins over a simultaneous start_i.
- States:
  - IDLE: on start_i, go to FETCH. Load addr_o←base_i, count_o←0, aborted_o←0, clear the abort latch.
  - FETCH: one wait cycle for memory latency; go to CHECK.
  - CHECK: sample data_i.
    - If data_i==TERM, or count_o==MAX_LEN, or the abort latch is set: go to FINISH.
    - Otherwise load the frame shifter, pull tx_o low (start bit), addr_o←addr_o+1 (prefetch), go to SEND.
  - SEND: shift the frame out: start bit, data bits LSB first, STOP_BITS stop bits. Each bit lasts exactly BAUD_DIV clocks. At the end of the last stop bit: count_o+1, go to CHECK. Prefetched data is already valid, so no FETCH is needed.
  - FINISH: done_o=1 for one cycle, aborted_o reflects the latch; go to IDLE.
- The baud counter restarts at every frame load. Bit timing is aligned to the load, not to a free-running tick.
- abort_i is latched in any non-IDLE state. The frame in flight always completes; no truncated frames.
- start_i while busy_o=1 is ignored, including the FINISH cycle.
- addr_o wraps modulo 2**ADDR_W; wrapping is not an error.
- Empty message (first byte TERM): done_o is pulsed, count_o=0, and tx_o never goes low.

## Timing
- Let E0 be the edge that accepts start_i:
  - addr_o=base_i after E0.
  - Memory data is valid after E1.
  - The start bit begins after E2.
- Frame length F = BAUD_DIV·(9+STOP_BITS) clocks.
- Inter-frame gap: exactly 1 idle-high clock (the CHECK cycle).
- Message of N bytes terminated by TERM: done_o is high in the cycle after edge E2+N·(F+1). For N=0, that is the cycle after E2.
- count_o increments on the edge that ends each stop bit.

## Structure
- Package string_tx_pkg holds:
  - the state enum (IDLE, FETCH, CHECK, SEND, FINISH);
  - the frame constants (START_BIT=0, STOP_LEVEL=1, DATA_BITS=8).
- One sub-module, uart_tx_core, contains the baud counter, bit counter and shifter, with a load/byte input and a frame_done output. The string_tx FSM owns addressing, termination, abort and counting.

## Test plan
- BAUD_DIV=4, STOP_BITS=1, memory "HI\0" at base 0x00, start_i:
  - tx_o carries frames 0x48 then 0x49, LSB first, 4 clocks/bit, with a 1-clock gap;
  - done_o pulses in the cycle after E84;
  - count_o=2, aborted_o=0.
- Base 0xFE holding 'A','B','C',0x00 with ADDR_W=8: addr_o wraps 0xFF→0x00; bytes 0x41,0x42,0x43 are sent; count_o=3.
- MAX_LEN=2, memory "HELLO\0": only 0x48,0x45 are sent; done_o pulses; count_o=2.
- abort_i pulsed mid-way through the first frame of "HI\0": frame 0x48 completes intact; done_o pulses; aborted_o=1; count_o=1.
- Empty string at base 0x10: done_o pulses after E2; tx_o stays high; count_o=0. A start_i asserted during the transfer has no effect.
- rst_i asserted in the middle of a data bit: tx_o=1, busy_o=0, count_o=0 after the next edge. A new start then transmits normally.

Source files
------------

// File: rtl/string_tx_pkg.sv
// Shared types and UART frame constants for the string transmitter.
// No logic here; imported by string_tx and uart_tx_core.
package string_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        SEND,
        FINISH
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_LEVEL = 1'b1;
    localparam int   DATA_BITS  = 8;

endpackage

// File: rtl/uart_tx_core.sv
// UART frame serialiser: start bit, 8 data bits LSB first, STOP_BITS stop bits, BAUD_DIV clocks per bit.
// Frame starts on the clock after load_i; frame_done_o flags the final cycle; load_i is only legal when idle.
module uart_tx_core
    import string_tx_pkg::*;
#(
    parameter int BAUD_DIV  = 208,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] byte_i,
    output logic                 tx_o,
    output logic                 frame_done_o
);

    localparam int NBITS = 1 + DATA_BITS + STOP_BITS;
    localparam int CW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BW    = $clog2(NBITS);
    localparam int SW    = DATA_BITS + STOP_BITS;

    logic [CW-1:0] baud_q, baud_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [SW-1:0] shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          active_q, active_d;
    logic          baud_end, last_bit;

    assign baud_end     = (baud_q == CW'(BAUD_DIV - 1));
    assign last_bit     = (bit_q == BW'(NBITS - 1));
    assign frame_done_o = active_q & baud_end & last_bit;
    assign tx_o         = tx_q;

    // The start bit is driven straight from the load, so the shifter holds data and stop bits only.
    always_comb begin
        baud_d   = baud_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        active_d = active_q;
        if (load_i) begin
            shreg_d  = {{STOP_BITS{STOP_LEVEL}}, byte_i};
            tx_d     = START_BIT;
            baud_d   = '0;
            bit_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (baud_end) begin
                baud_d = '0;
                if (last_bit) begin
                    active_d = 1'b0;
                    tx_d     = STOP_LEVEL;
                end else begin
                    tx_d    = shreg_q[0];
                    shreg_d = {STOP_LEVEL, shreg_q[SW-1:1]};
                    bit_d   = bit_q + 1'b1;
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= STOP_LEVEL;
            active_q <= 1'b0;
        end else begin
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/string_tx.sv
// Walks a byte memory from base_i and sends each byte as a UART frame until TERM, MAX_LEN or abort.
// First start bit 2 clocks after start_i; start_i ignored while busy_o; abort_i takes effect after the current frame.
module string_tx
    import string_tx_pkg::*;
#(
    parameter int         BAUD_DIV  = 208,
    parameter int         ADDR_W    = 8,
    parameter int         STOP_BITS = 1,
    parameter logic [7:0] TERM      = 8'h00,
    parameter int         MAX_LEN   = 2 ** ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [7:0]        data_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [ADDR_W:0]   count_o
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_LEN);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              abort_q, abort_d;
    logic              aborted_q, aborted_d;
    logic              stop_msg, load, frame_done;

    assign stop_msg = (data_i == TERM) | (count_q == MAX_CNT) | abort_q;

    uart_tx_core #(
        .BAUD_DIV  (BAUD_DIV),
        .STOP_BITS (STOP_BITS)
    ) u_core (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (load),
        .byte_i       (data_i),
        .tx_o         (tx_o),
        .frame_done_o (frame_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = FETCH;
            FETCH:   state_d = CHECK;
            CHECK:   state_d = stop_msg ? FINISH : SEND;
            SEND:    if (frame_done) state_d = CHECK;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == FINISH);
        load   = (state_q == CHECK) && !stop_msg;
    end

    // Prefetch on load: the next byte is valid by the time the frame ends.
    always_comb begin
        addr_d    = addr_q;
        count_d   = count_q;
        abort_d   = abort_q;
        aborted_d = aborted_q;
        if (state_q == IDLE) begin
            if (start_i) begin
                addr_d    = base_i;
                count_d   = '0;
                abort_d   = 1'b0;
                aborted_d = 1'b0;
            end
        end else if (abort_i) begin
            abort_d = 1'b1;
        end
        if (load)
            addr_d = addr_q + 1'b1;
        if (frame_done)
            count_d = count_q + 1'b1;
        if ((state_q == CHECK) && stop_msg)
            aborted_d = abort_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            count_q   <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            count_q   <= count_d;
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
        end
    end

    assign addr_o    = addr_q;
    assign count_o   = count_q;
    assign aborted_o = aborted_q;

endmodule
